reg_cmd_ctrl: RTL and testbench
===============================

# reg_cmd_ctrl

Command initiator for the register file. Decodes byte frames from the UART receive path into single-cycle register file writes and reads. Returns read data as one byte to the UART transmit path. Sits between the RX deserializer, the register file's WrEn/RdEn/Address/WrData/RdData/RdData_VLD port, and the TX serializer.

## Interface
- DATA_WIDTH, 8, byte and register width
- ADDR, 4, register address width
- WR_CMD, 8'hAA, write-frame opcode
- RD_CMD, 8'hBB, read-frame opcode
- RD_TIMEOUT, 15, max cycles waiting for RdData_VLD (≥1)

Clocking is decided: one clock; reset is synchronous and active-high.
- CLK  in  1  system clock
- RST  in  1  synchronous active-high reset
- RX_P_DATA  in  DATA_WIDTH  received byte
- RX_D_VLD  in  1  one-cycle strobe, RX_P_DATA valid
- RdData  in  DATA_WIDTH  register file read data
- RdData_VLD  in  1  register file read-data valid
- TX_BUSY  in  1  transmitter busy, byte cannot be accepted
- WrEn  out  1  register write strobe
- RdEn  out  1  register read strobe
- Address  out  ADDR  register address
- WrData  out  DATA_WIDTH  register write data
- TX_P_DATA  out  DATA_WIDTH  byte to transmit
- TX_D_VLD  out  1  one-cycle strobe, TX_P_DATA valid
- CMD_ERR  out  1  one-cycle pulse: unknown opcode or read timeout

## Operation
- Frames:
  - Write = WR_CMD, addr, data.
  - Read = RD_CMD, addr.
  - addr uses the low ADDR bits of the byte; upper bits are ignored.
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND.
- IDLE, on RX_D_VLD:
  - WR_CMD → WR_ADDR.
  - RD_CMD → RD_ADDR.
  - Any other byte → pulse CMD_ERR and stay in IDLE.
- WR_ADDR: on RX_D_VLD, latch Address → WR_DATA.
- WR_DATA: on RX_D_VLD, latch WrData, assert WrEn for exactly one cycle → IDLE.
- RD_ADDR: on RX_D_VLD, latch Address, assert RdEn for exactly one cycle, clear timeout counter → RD_WAIT.
- RD_WAIT:
  - On RdData_VLD, capture RdData into the TX_P_DATA register → TX_SEND.
  - Otherwise increment the counter.
  - When the counter reaches RD_TIMEOUT → pulse CMD_ERR, go to IDLE, leave TX_P_DATA unchanged.
- TX_SEND: at the first edge where TX_BUSY is sampled low, assert TX_D_VLD for one cycle → IDLE. TX_BUSY high holds the state indefinitely with no timeout.
- RX_D_VLD in RD_WAIT or TX_SEND: byte is dropped and does not start a new frame.
- RdData_VLD outside RD_WAIT: ignored.
- WrEn and RdEn are never high in the same cycle.
- Address and WrData hold their last value between operations.
- All outputs are registered. No combinational path from input to output.
- Timeout counter: ceil(log2(RD_TIMEOUT+1)) bits, saturating, cleared on entry to RD_WAIT.

## Timing
- Reset (RST high at an edge):
  - State returns to IDLE.
  - WrEn, RdEn, TX_D_VLD, CMD_ERR = 0.
  - Address = 0, WrData = 0, TX_P_DATA = 0, counter = 0.
  - A partial frame is discarded; an in-flight read response is discarded.
- Write: data byte sampled at edge k → WrEn=1 with Address/WrData valid from edge k until edge k+1. The register file commits at k+1.
- Read: addr byte at edge k → RdEn=1 during k..k+1.
- Single-cycle register file response: RdData_VLD high during k+1..k+2, captured at k+2.
- TX_BUSY low at k+3 → TX_D_VLD high during k+3..k+4.
- Minimum frame spacing: the next opcode is accepted from the edge after WrEn (write) or after TX_D_VLD (read).
- CMD_ERR goes high the cycle after the offending byte, or the cycle after the counter reaches RD_TIMEOUT.
- Back-to-back RX_D_VLD on consecutive cycles is supported through a full write frame.

## Test plan
- Reset, then RX bytes AA,03,5C → one WrEn pulse with Address=3, WrData=5C; CMD_ERR stays 0.
- After that write, RX BB,03 with a 1-cycle-latency register file model → RdEn pulse with Address=3, then TX_D_VLD pulse with TX_P_DATA=5C.
- Read with TX_BUSY held high 20 cycles after capture → no TX_D_VLD while busy; exactly one TX_D_VLD with correct data on the cycle after TX_BUSY falls.
- RX byte 7E in IDLE → one CMD_ERR pulse, no WrEn/RdEn. The following AA,01,FF still writes 01←FF.
- RX BB,02 with RdData_VLD never asserted → CMD_ERR pulse RD_TIMEOUT cycles after RdEn, then return to IDLE. A late RdData_VLD is ignored and no TX_D_VLD occurs.
- RST high after AA,05 (before the data byte) → no WrEn. The following byte 11 produces CMD_ERR (treated as an opcode); all outputs read their reset values.

Source files
------------

// File: rtl/reg_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// reg_cmd_ctrl
//
// Command initiator for the register file. Decodes byte frames arriving from
// the UART receive path into single-cycle register file writes and reads, and
// hands read data back to the UART transmit path as one byte.
//
//   Write frame : WR_CMD, addr, data
//   Read frame  : RD_CMD, addr   -> RdData returned on TX_P_DATA/TX_D_VLD
//
// Ports
//   CLK         in   system clock
//   RST         in   synchronous active-high reset
//   RX_P_DATA   in   received byte
//   RX_D_VLD    in   one-cycle strobe, RX_P_DATA valid
//   RdData      in   register file read data
//   RdData_VLD  in   register file read-data valid
//   TX_BUSY     in   transmitter busy, byte cannot be accepted
//   WrEn        out  register write strobe (one cycle)
//   RdEn        out  register read strobe (one cycle)
//   Address     out  register address (holds between operations)
//   WrData      out  register write data (holds between operations)
//   TX_P_DATA   out  byte to transmit
//   TX_D_VLD    out  one-cycle strobe, TX_P_DATA valid
//   CMD_ERR     out  one-cycle pulse: unknown opcode or read timeout
//
// Every output is a flop; there is no combinational input-to-output path.
// -----------------------------------------------------------------------------
module reg_cmd_ctrl #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR       = 4,
    parameter logic [DATA_WIDTH-1:0] WR_CMD     = 8'hAA,
    parameter logic [DATA_WIDTH-1:0] RD_CMD     = 8'hBB,
    parameter int                    RD_TIMEOUT = 15
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    input  logic [DATA_WIDTH-1:0] RdData,
    input  logic                  RdData_VLD,
    input  logic                  TX_BUSY,
    output logic                  WrEn,
    output logic                  RdEn,
    output logic [ADDR-1:0]       Address,
    output logic [DATA_WIDTH-1:0] WrData,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_D_VLD,
    output logic                  CMD_ERR
);

    localparam int               CNT_W   = $clog2(RD_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RD_TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_WAIT,
        TX_SEND
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] rd_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            WrEn      <= 1'b0;
            RdEn      <= 1'b0;
            TX_D_VLD  <= 1'b0;
            CMD_ERR   <= 1'b0;
            Address   <= '0;
            WrData    <= '0;
            TX_P_DATA <= '0;
            rd_cnt    <= '0;
        end else begin
            // NOTE: strobes default low every cycle, so any branch that raises
            // one produces exactly a single-cycle pulse without extra clearing.
            WrEn     <= 1'b0;
            RdEn     <= 1'b0;
            TX_D_VLD <= 1'b0;
            CMD_ERR  <= 1'b0;

            case (state)
                IDLE: begin
                    if (RX_D_VLD) begin
                        if (RX_P_DATA == WR_CMD) begin
                            state <= WR_ADDR;
                        end else if (RX_P_DATA == RD_CMD) begin
                            state <= RD_ADDR;
                        end else begin
                            CMD_ERR <= 1'b1;
                        end
                    end
                end

                WR_ADDR: begin
                    if (RX_D_VLD) begin
                        Address <= RX_P_DATA[ADDR-1:0];
                        state   <= WR_DATA;
                    end
                end

                WR_DATA: begin
                    if (RX_D_VLD) begin
                        WrData <= RX_P_DATA;
                        WrEn   <= 1'b1;
                        state  <= IDLE;
                    end
                end

                RD_ADDR: begin
                    if (RX_D_VLD) begin
                        Address <= RX_P_DATA[ADDR-1:0];
                        RdEn    <= 1'b1;
                        rd_cnt  <= '0;
                        state   <= RD_WAIT;
                    end
                end

                // A response arriving on the same edge the counter expires
                // still wins; the timeout only fires when nothing came back.
                RD_WAIT: begin
                    if (RdData_VLD) begin
                        TX_P_DATA <= RdData;
                        state     <= TX_SEND;
                    end else if (rd_cnt == CNT_MAX) begin
                        CMD_ERR <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        rd_cnt <= rd_cnt + 1'b1;
                    end
                end

                // The transmitter may stay busy arbitrarily long; we wait.
                TX_SEND: begin
                    if (!TX_BUSY) begin
                        TX_D_VLD <= 1'b1;
                        state    <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_reg_cmd_ctrl
//
// Directed bench for reg_cmd_ctrl. Inputs are driven on the falling edge,
// outputs are read on the falling edge or 1 ns after the rising edge. A small
// one-cycle-latency register file model answers RdEn; it can be disabled to
// provoke the read timeout, and a late RdData_VLD can be injected by hand.
// -----------------------------------------------------------------------------
module tb_reg_cmd_ctrl;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int TO = 15;

    logic          CLK = 1'b0;
    logic          RST;
    logic [DW-1:0] RX_P_DATA;
    logic          RX_D_VLD;
    logic [DW-1:0] RdData;
    logic          RdData_VLD;
    logic          TX_BUSY;
    logic          WrEn;
    logic          RdEn;
    logic [AW-1:0] Address;
    logic [DW-1:0] WrData;
    logic [DW-1:0] TX_P_DATA;
    logic          TX_D_VLD;
    logic          CMD_ERR;

    reg_cmd_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR       (AW),
        .WR_CMD     (8'hAA),
        .RD_CMD     (8'hBB),
        .RD_TIMEOUT (TO)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_P_DATA  (RX_P_DATA),
        .RX_D_VLD   (RX_D_VLD),
        .RdData     (RdData),
        .RdData_VLD (RdData_VLD),
        .TX_BUSY    (TX_BUSY),
        .WrEn       (WrEn),
        .RdEn       (RdEn),
        .Address    (Address),
        .WrData     (WrData),
        .TX_P_DATA  (TX_P_DATA),
        .TX_D_VLD   (TX_D_VLD),
        .CMD_ERR    (CMD_ERR)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // Pulse counters, cleared by the stimulus between scenarios.
    int wr_cnt, rd_cnt, tx_cnt, err_cnt, both_cnt;

    // Register file model controls.
    logic          rf_en;
    logic          force_vld;
    logic [DW-1:0] force_data;
    logic          rf_pend;
    logic [DW-1:0] rf_q;
    logic [DW-1:0] rf_mem [16];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Presents one byte for one cycle. Called on a falling edge, returns on
    // the next falling edge, so consecutive calls give back-to-back strobes.
    task automatic rx(input logic [DW-1:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        @(negedge CLK);
        RX_D_VLD  = 1'b0;
    endtask

    task automatic clear_counts();
        wr_cnt = 0; rd_cnt = 0; tx_cnt = 0; err_cnt = 0;
    endtask

    // Monitor and register file model, evaluated 1 ns after each rising edge.
    always begin
        @(posedge CLK);
        #1;
        if (WrEn)           wr_cnt++;
        if (RdEn)           rd_cnt++;
        if (TX_D_VLD)       tx_cnt++;
        if (CMD_ERR)        err_cnt++;
        if (WrEn && RdEn)   both_cnt++;
        RdData_VLD = rf_pend || force_vld;
        RdData     = force_vld ? force_data : rf_q;
        rf_pend    = RdEn && rf_en;
        rf_q       = rf_mem[Address];
        if (WrEn) rf_mem[Address] = WrData;
    end

    initial begin
        int first_err;

        RST        = 1'b1;
        RX_P_DATA  = '0;
        RX_D_VLD   = 1'b0;
        TX_BUSY    = 1'b0;
        RdData     = '0;
        RdData_VLD = 1'b0;
        rf_en      = 1'b1;
        force_vld  = 1'b0;
        force_data = '0;
        rf_pend    = 1'b0;
        rf_q       = '0;
        both_cnt   = 0;
        for (int i = 0; i < 16; i++) rf_mem[i] = '0;
        clear_counts();

        // ---- Reset state -----------------------------------------------------
        repeat (2) @(negedge CLK);
        check("rst_wren",  {31'd0, WrEn},     32'd0);
        check("rst_rden",  {31'd0, RdEn},     32'd0);
        check("rst_txvld", {31'd0, TX_D_VLD}, 32'd0);
        check("rst_err",   {31'd0, CMD_ERR},  32'd0);
        check("rst_addr",  {28'd0, Address},  32'd0);
        check("rst_wdata", {24'd0, WrData},   32'd0);
        check("rst_txd",   {24'd0, TX_P_DATA}, 32'd0);
        RST = 1'b0;
        @(negedge CLK);

        // ---- Write AA,03,5C back to back ------------------------------------
        clear_counts();
        rx(8'hAA); rx(8'h03); rx(8'h5C);
        check("wr1_wren",  {31'd0, WrEn},    32'd1);
        check("wr1_addr",  {28'd0, Address}, 32'h3);
        check("wr1_wdata", {24'd0, WrData},  32'h5C);
        @(negedge CLK);
        check("wr1_wren_drop", {31'd0, WrEn}, 32'd0);
        repeat (2) @(negedge CLK);
        check("wr1_wr_pulses", wr_cnt,  32'd1);
        check("wr1_err",       err_cnt, 32'd0);

        // ---- Read BB,03 with one-cycle register file ------------------------
        clear_counts();
        rx(8'hBB); rx(8'h03);                        // edge k
        check("rd1_rden", {31'd0, RdEn},    32'd1);
        check("rd1_addr", {28'd0, Address}, 32'h3);
        @(negedge CLK);                              // after k+1
        check("rd1_rden_drop", {31'd0, RdEn}, 32'd0);
        @(negedge CLK);                              // after k+2: captured
        check("rd1_capture", {24'd0, TX_P_DATA},  32'h5C);
        check("rd1_txvld_early", {31'd0, TX_D_VLD}, 32'd0);
        @(negedge CLK);                              // after k+3
        check("rd1_txvld", {31'd0, TX_D_VLD},  32'd1);
        check("rd1_txd",   {24'd0, TX_P_DATA}, 32'h5C);
        @(negedge CLK);
        check("rd1_txvld_drop", {31'd0, TX_D_VLD}, 32'd0);
        @(negedge CLK);
        check("rd1_rd_pulses", rd_cnt, 32'd1);
        check("rd1_tx_pulses", tx_cnt, 32'd1);

        // ---- Write 07<-A5, then read it while the transmitter is busy -------
        rx(8'hAA); rx(8'h07); rx(8'hA5);
        @(negedge CLK);
        clear_counts();
        TX_BUSY = 1'b1;
        rx(8'hBB); rx(8'h07);
        repeat (2) @(negedge CLK);                   // captured at k+2
        check("busy_capture", {24'd0, TX_P_DATA}, 32'hA5);
        repeat (20) @(negedge CLK);
        check("busy_no_tx", tx_cnt, 32'd0);
        TX_BUSY = 1'b0;
        @(negedge CLK);
        check("busy_txvld", {31'd0, TX_D_VLD},  32'd1);
        check("busy_txd",   {24'd0, TX_P_DATA}, 32'hA5);
        @(negedge CLK);
        check("busy_txvld_drop", {31'd0, TX_D_VLD}, 32'd0);
        @(negedge CLK);
        check("busy_tx_pulses", tx_cnt, 32'd1);

        // ---- Unknown opcode, then a normal write ----------------------------
        clear_counts();
        rx(8'h7E);
        check("bad_err", {31'd0, CMD_ERR}, 32'd1);
        @(negedge CLK);
        check("bad_err_drop", {31'd0, CMD_ERR}, 32'd0);
        rx(8'hAA); rx(8'h01); rx(8'hFF);
        check("wr2_wren",  {31'd0, WrEn},    32'd1);
        check("wr2_addr",  {28'd0, Address}, 32'h1);
        check("wr2_wdata", {24'd0, WrData},  32'hFF);
        repeat (2) @(negedge CLK);
        check("bad_err_pulses", err_cnt, 32'd1);
        check("bad_wr_pulses",  wr_cnt,  32'd1);
        check("bad_rd_pulses",  rd_cnt,  32'd0);

        // ---- Read timeout: register file never answers ----------------------
        clear_counts();
        rf_en = 1'b0;
        rx(8'hBB); rx(8'h02);                        // RdEn visible now
        check("to_rden", {31'd0, RdEn}, 32'd1);
        first_err = 0;
        for (int i = 1; i <= TO + 5; i++) begin
            @(negedge CLK);
            if (CMD_ERR && first_err == 0) first_err = i;
        end
        check("to_latency",   first_err, TO + 1);
        check("to_err_pulses", err_cnt,  32'd1);
        force_data = 8'h77;
        force_vld  = 1'b1;
        repeat (3) @(negedge CLK);
        force_vld  = 1'b0;
        repeat (4) @(negedge CLK);
        check("to_late_no_tx", tx_cnt, 32'd0);
        check("to_txd_kept", {24'd0, TX_P_DATA}, 32'hA5);
        rf_en = 1'b1;

        // ---- Reset in the middle of a write frame ---------------------------
        clear_counts();
        rx(8'hAA); rx(8'h05);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("mid_addr",  {28'd0, Address},   32'd0);
        check("mid_wdata", {24'd0, WrData},    32'd0);
        check("mid_txd",   {24'd0, TX_P_DATA}, 32'd0);
        check("mid_flags", {28'd0, WrEn, RdEn, TX_D_VLD, CMD_ERR}, 32'd0);
        rx(8'h11);
        check("mid_err",  {31'd0, CMD_ERR}, 32'd1);
        check("mid_wren", {31'd0, WrEn},    32'd0);
        repeat (2) @(negedge CLK);
        check("mid_wr_pulses", wr_cnt, 32'd0);

        check("never_wr_and_rd", both_cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
